traffic_light_monitor: RTL and testbench

Passive checker that sits on the consumer side of the traffic-light controller's NS_light/EW_light outputs. It samples both light buses every clock and tracks the expected intersection phase. It flags illegal encodings, conflicting greens, illegal phase transitions and yellow/green timing violations, and it counts completed light cycles. It is used in simulation benches and on the board next to the controller. It never drives the lights.

---
 rtl/traffic_pkg.sv | 44 ++++
 rtl/tl_pair_classify.sv | 28 ++
 rtl/traffic_light_monitor.sv | 137 +++++++++++++
 tb/tb_traffic_light_monitor.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared lamp encodings, tracked phases, pair classes and error bit positions
// for the traffic-light monitor and its pair classifier.
package traffic_pkg;

  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;

  typedef enum logic [2:0] {
    P_SYNC = 3'd0,
    P_NS_G = 3'd1,
    P_NS_Y = 3'd2,
    P_AR1  = 3'd3,
    P_EW_G = 3'd4,
    P_EW_Y = 3'd5,
    P_AR2  = 3'd6
  } phase_t;

  typedef enum logic [2:0] {
    PC_NS_G  = 3'd0,
    PC_NS_Y  = 3'd1,
    PC_AR    = 3'd2,
    PC_EW_G  = 3'd3,
    PC_EW_Y  = 3'd4,
    PC_OTHER = 3'd5
  } pair_cls_t;

  typedef struct packed {
    logic [2:0] ns;
    logic [2:0] ew;
  } light_pair_t;

  localparam int unsigned ERR_W      = 5;
  localparam int unsigned ERR_ENC    = 0;
  localparam int unsigned ERR_CONFL  = 1;
  localparam int unsigned ERR_TRANS  = 2;
  localparam int unsigned ERR_YEL_T  = 3;
  localparam int unsigned ERR_GRN_T  = 4;

  function automatic logic is_onehot(input logic [2:0] v);
    return (v == LT_RED) || (v == LT_YEL) || (v == LT_GRN);
  endfunction

endpackage

// File: rtl/tl_pair_classify.sv
// Combinational classifier: maps an {NS,EW} lamp pair to its phase class and
// flags bad encodings and conflicting (both non-red) lamps.
module tl_pair_classify
  import traffic_pkg::*;
(
  input  logic [2:0] ns,
  input  logic [2:0] ew,
  output logic [2:0] cls_c,
  output logic       enc_err_c,
  output logic       conflict_c
);

  pair_cls_t cls;

  always_comb begin
    cls        = PC_OTHER;
    enc_err_c  = !is_onehot(ns) || !is_onehot(ew);
    conflict_c = (ns != LT_RED) && (ew != LT_RED);
    if      (ns == LT_GRN && ew == LT_RED) cls = PC_NS_G;
    else if (ns == LT_YEL && ew == LT_RED) cls = PC_NS_Y;
    else if (ns == LT_RED && ew == LT_RED) cls = PC_AR;
    else if (ns == LT_RED && ew == LT_GRN) cls = PC_EW_G;
    else if (ns == LT_RED && ew == LT_YEL) cls = PC_EW_Y;
  end

  assign cls_c = cls;

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker for the traffic-light controller outputs: tracks the
// intersection phase, flags encoding/conflict/transition/timing errors.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int unsigned YELLOW_CYCLES = 2,
  parameter int unsigned GREEN_MIN     = 4,
  parameter int unsigned CNT_W         = 4,
  parameter int unsigned CYC_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       NS_light,
  input  logic [2:0]       EW_light,
  input  logic             err_clr,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] dwell,
  output logic             err_pulse,
  output logic [4:0]       err_code,
  output logic [4:0]       err_sticky,
  output logic [CYC_W-1:0] cycles_done
);

  localparam logic [CNT_W-1:0] DWELL_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] GRN_MIN_C = CNT_W'(GREEN_MIN);
  localparam logic [CNT_W-1:0] YEL_C     = CNT_W'(YELLOW_CYCLES);

  phase_t            phase_q, phase_d;
  light_pair_t       prev_q, cur;
  logic              prev_valid_q;
  logic [CNT_W-1:0]  dwell_d;
  logic [ERR_W-1:0]  err_d, sticky_d;
  logic [CYC_W-1:0]  cyc_d;
  logic              changed, legal;
  logic [2:0]        cls_raw;
  pair_cls_t         cls;
  logic              enc_err, conflict;

  tl_pair_classify u_classify (
    .ns         (NS_light),
    .ew         (EW_light),
    .cls_c      (cls_raw),
    .enc_err_c  (enc_err),
    .conflict_c (conflict)
  );

  assign cls = pair_cls_t'(cls_raw);
  assign cur = '{ns: NS_light, ew: EW_light};

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q      <= P_SYNC;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      dwell        <= '0;
      err_pulse    <= 1'b0;
      err_code     <= '0;
      err_sticky   <= '0;
      cycles_done  <= '0;
    end else begin
      phase_q      <= phase_d;
      prev_q       <= cur;
      prev_valid_q <= 1'b1;
      dwell        <= dwell_d;
      err_pulse    <= |err_d;
      err_code     <= err_d;
      err_sticky   <= sticky_d;
      cycles_done  <= cyc_d;
    end
  end

  // Phase tracking, error detection and dwell/cycle bookkeeping.
  always_comb begin
    phase_d  = phase_q;
    err_d    = '0;
    cyc_d    = cycles_done;
    legal    = 1'b0;
    changed  = !prev_valid_q || (cur != prev_q);
    dwell_d  = changed ? CNT_W'(1) :
               (dwell == DWELL_MAX) ? dwell : dwell + CNT_W'(1);

    err_d[ERR_ENC]   = enc_err;
    err_d[ERR_CONFL] = conflict;

    if (phase_q == P_SYNC) begin
      if (cls == PC_NS_G) phase_d = P_NS_G;
      else if (cls == PC_EW_G) phase_d = P_EW_G;
    end else if (changed) begin
      case (phase_q)
        P_NS_G: if (cls == PC_NS_Y) begin
          legal   = 1'b1;
          phase_d = P_NS_Y;
          if (dwell < GRN_MIN_C) err_d[ERR_GRN_T] = 1'b1;
        end
        P_NS_Y: if (cls == PC_AR) begin
          legal   = 1'b1;
          phase_d = P_AR1;
          if (dwell < YEL_C) err_d[ERR_YEL_T] = 1'b1;
        end
        P_AR1: if (cls == PC_EW_G) begin
          legal   = 1'b1;
          phase_d = P_EW_G;
        end
        P_EW_G: if (cls == PC_EW_Y) begin
          legal   = 1'b1;
          phase_d = P_EW_Y;
          if (dwell < GRN_MIN_C) err_d[ERR_GRN_T] = 1'b1;
        end
        P_EW_Y: if (cls == PC_AR) begin
          legal   = 1'b1;
          phase_d = P_AR2;
          if (dwell < YEL_C) err_d[ERR_YEL_T] = 1'b1;
        end
        P_AR2: if (cls == PC_NS_G) begin
          legal   = 1'b1;
          phase_d = P_NS_G;
          cyc_d   = cycles_done + CYC_W'(1);
        end
        default: legal = 1'b0;
      endcase
      if (!legal) begin
        err_d[ERR_TRANS] = 1'b1;
        phase_d          = P_SYNC;
      end
    end else if ((phase_q == P_NS_Y || phase_q == P_EW_Y) && dwell == YEL_C) begin
      // Overlong yellow is flagged once, on the step from YELLOW_CYCLES to +1.
      err_d[ERR_YEL_T] = 1'b1;
    end

    if (enc_err || conflict) phase_d = P_SYNC;

    sticky_d = err_clr ? err_d : (err_sticky | err_d);
  end

  assign phase = phase_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor: each driven sample pushes its
// expected outputs; a negedge monitor pops and compares one cycle later.
module tb_traffic_light_monitor;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;
  localparam logic [5:0] NSG = {G, R};
  localparam logic [5:0] NSY = {Y, R};
  localparam logic [5:0] AR  = {R, R};
  localparam logic [5:0] EWG = {R, G};
  localparam logic [5:0] EWY = {R, Y};
  localparam logic [5:0] GG  = {G, G};
  localparam logic [5:0] BAD = {3'b011, R};

  typedef struct packed {
    logic [2:0] phase;
    logic [3:0] dwell;
    logic       pulse;
    logic [4:0] code;
    logic [4:0] sticky;
    logic [7:0] cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, err_clr;
  logic [2:0] ns_light, ew_light;
  logic [2:0] phase;
  logic [3:0] dwell;
  logic       err_pulse;
  logic [4:0] err_code, err_sticky;
  logic [7:0] cycles_done;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];

  logic [5:0] m_prev;
  logic       m_valid;
  int         m_dwell;
  logic [4:0] m_sticky;
  logic [7:0] m_cyc;
  logic [2:0] m_phase;

  traffic_light_monitor dut (
    .clk         (clk),
    .rst         (rst),
    .NS_light    (ns_light),
    .EW_light    (ew_light),
    .err_clr     (err_clr),
    .phase       (phase),
    .dwell       (dwell),
    .err_pulse   (err_pulse),
    .err_code    (err_code),
    .err_sticky  (err_sticky),
    .cycles_done (cycles_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
  endtask

  // Drive one sample; the expected phase and error code are hand-derived per step,
  // dwell/sticky/cycle expectations are book-kept here.
  task automatic step(input logic r, input logic [5:0] pair, input logic clr,
                      input logic [2:0] ep, input logic [4:0] ec);
    exp_t e;
    rst      = r;
    ns_light = pair[5:3];
    ew_light = pair[2:0];
    err_clr  = clr;
    if (r) begin
      m_valid = 1'b0; m_dwell = 0; m_sticky = '0; m_cyc = '0; m_phase = '0;
      e = '0;
    end else begin
      if (!m_valid || pair != m_prev) m_dwell = 1;
      else if (m_dwell < 15) m_dwell++;
      m_prev   = pair;
      m_valid  = 1'b1;
      m_sticky = clr ? ec : (m_sticky | ec);
      if (m_phase == 3'd6 && ep == 3'd1) m_cyc++;
      m_phase  = ep;
      e = '{phase: ep, dwell: 4'(m_dwell), pulse: |ec, code: ec, sticky: m_sticky, cyc: m_cyc};
    end
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic hold(input logic [5:0] pair, input int n, input logic [2:0] ep);
    for (int i = 0; i < n; i++) step(1'b0, pair, 1'b0, ep, 5'b00000);
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      check("phase",       32'(phase),       32'(e.phase));
      check("dwell",       32'(dwell),       32'(e.dwell));
      check("err_pulse",   32'(err_pulse),   32'(e.pulse));
      check("err_code",    32'(err_code),    32'(e.code));
      check("err_sticky",  32'(err_sticky),  32'(e.sticky));
      check("cycles_done", 32'(cycles_done), 32'(e.cyc));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; err_clr = 1'b0; ns_light = R; ew_light = R;
    m_prev = '0; m_valid = 1'b0; m_dwell = 0; m_sticky = '0; m_cyc = '0; m_phase = '0;

    // 1: reset, three legal cycles, closing NS_G completes the third cycle
    step(1'b1, AR, 1'b0, 3'd0, 5'b00000);
    for (int r = 0; r < 3; r++) begin
      hold(NSG, 5, 3'd1); hold(NSY, 2, 3'd2); hold(AR, 1, 3'd3);
      hold(EWG, 5, 3'd4); hold(EWY, 2, 3'd5); hold(AR, 1, 3'd6);
    end
    hold(NSG, 1, 3'd1);

    // 2: skip yellow, then resync on NS green
    hold(NSG, 3, 3'd1);
    step(1'b0, AR, 1'b0, 3'd0, 5'b00100);
    hold(AR, 1, 3'd0);
    hold(NSG, 1, 3'd1);

    // 3a: short yellow
    hold(NSG, 4, 3'd1);
    step(1'b0, NSY, 1'b0, 3'd2, 5'b00000);
    step(1'b0, AR,  1'b0, 3'd3, 5'b01000);

    // 3b: fresh run, overlong yellow flagged once at dwell 3; green of exactly GREEN_MIN
    step(1'b1, AR, 1'b0, 3'd0, 5'b00000);
    hold(NSG, 4, 3'd1);
    step(1'b0, NSY, 1'b0, 3'd2, 5'b00000);
    step(1'b0, NSY, 1'b0, 3'd2, 5'b00000);
    step(1'b0, NSY, 1'b0, 3'd2, 5'b01000);
    step(1'b0, NSY, 1'b0, 3'd2, 5'b00000);
    step(1'b0, AR,  1'b0, 3'd3, 5'b00000);

    // 4: conflict and bad encoding, from tracked phases and while in sync
    step(1'b0, GG,  1'b0, 3'd0, 5'b00110);
    hold(AR, 1, 3'd0);
    hold(NSG, 1, 3'd1);
    step(1'b0, BAD, 1'b0, 3'd0, 5'b00101);
    step(1'b0, BAD, 1'b0, 3'd0, 5'b00001);
    step(1'b0, GG,  1'b0, 3'd0, 5'b00010);
    hold(AR, 1, 3'd0);

    // 5: short EW green, then err_clr colliding with a TRANS error
    hold(NSG, 4, 3'd1);
    hold(NSY, 2, 3'd2);
    hold(AR, 1, 3'd3);
    hold(EWG, 2, 3'd4);
    step(1'b0, EWY, 1'b0, 3'd5, 5'b10000);
    hold(EWY, 1, 3'd5);
    hold(AR, 1, 3'd6);
    step(1'b0, EWG, 1'b1, 3'd0, 5'b00100);
    step(1'b0, EWG, 1'b1, 3'd4, 5'b00000);

    // 6: reset during EW yellow with sticky errors, then yellow in sync is silent
    hold(EWG, 1, 3'd4);
    step(1'b0, EWY, 1'b0, 3'd5, 5'b10000);
    hold(EWY, 1, 3'd5);
    step(1'b1, EWY, 1'b0, 3'd0, 5'b00000);
    hold(EWY, 3, 3'd0);
    hold(EWG, 17, 3'd4);
    step(1'b0, EWY, 1'b0, 3'd5, 5'b00000);

    repeat (2) @(negedge clk);
    if (sb.size() != 0) check("scoreboard_drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
